// File: rtl/float_io_port_if.sv
// Processor peripheral bus plus the external operand/result pins of float_io_port.
// master = processor/environment side, slave = the port itself.
interface float_io_port_if;
  logic [3:0]  addr;
  logic [7:0]  wdata;
  logic        we;
  logic        re;
  logic [7:0]  rdata;
  logic [31:0] din;
  logic        din_rdy;
  logic        din_req;
  logic [31:0] dout;
  logic        dout_rdy;

  modport master (
    output addr, wdata, we, re, din, din_rdy,
    input  rdata, din_req, dout, dout_rdy
  );

  modport slave (
    input  addr, wdata, we, re, din, din_rdy,
    output rdata, din_req, dout, dout_rdy
  );
endinterface

// File: rtl/float_io_port.sv
// Memory-mapped port moving 32-bit operands/results between an 8-bit processor
// and the external din_req/din/din_rdy request and dout/dout_rdy strobe.
module float_io_port #(
  parameter int unsigned DOUT_HOLD = 4,
  parameter int unsigned DOUT_GAP  = 2
) (
  input logic             clk,
  input logic             rst_n,
  float_io_port_if.slave  io
);

  localparam logic [1:0] IN_IDLE  = 2'd0;
  localparam logic [1:0] IN_WAIT  = 2'd1;
  localparam logic [1:0] IN_FULL  = 2'd2;
  localparam logic [1:0] OUT_IDLE = 2'd0;
  localparam logic [1:0] OUT_HOLD = 2'd1;
  localparam logic [1:0] OUT_GAP  = 2'd2;

  localparam logic [7:0] HOLD_CNT = 8'(DOUT_HOLD);
  localparam logic [7:0] GAP_CNT  = 8'(DOUT_GAP);

  logic [1:0]       in_state_q, in_state_d;
  logic [31:0]      in_word_q, in_word_d;
  logic [1:0]       out_state_q, out_state_d;
  logic [31:0]      dout_q, dout_d;
  logic [3:0][7:0]  out_b_q, out_b_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             ovr_q, ovr_d;

  logic       wr_ctrl, req, send, clr, consume, can_accept;
  logic [3:0] shadow_sel;

  always_comb begin
    wr_ctrl    = io.we && (io.addr == 4'h0);
    req        = wr_ctrl && io.wdata[0];
    send       = wr_ctrl && io.wdata[1];
    clr        = wr_ctrl && io.wdata[7];
    consume    = io.re && (io.addr == 4'h4);
    shadow_sel = io.addr - 4'd5;
    // The last gap cycle already counts as idle so the next SEND lands exactly
    // DOUT_HOLD+DOUT_GAP edges after the previous one.
    can_accept = (out_state_q == OUT_IDLE) ||
                 ((out_state_q == OUT_GAP) && (cnt_q == 8'd1));

    in_state_d = in_state_q;
    in_word_d  = in_word_q;
    case (in_state_q)
      IN_IDLE: if (req) in_state_d = IN_WAIT;
      IN_WAIT: if (io.din_rdy) begin
        in_word_d  = io.din;
        in_state_d = IN_FULL;
      end
      IN_FULL: begin
        if (req)          in_state_d = IN_WAIT;
        else if (consume) in_state_d = IN_IDLE;
      end
      default: in_state_d = IN_IDLE;
    endcase

    out_state_d = out_state_q;
    cnt_d       = cnt_q;
    dout_d      = dout_q;
    case (out_state_q)
      OUT_HOLD: begin
        if (cnt_q == 8'd1) begin
          out_state_d = OUT_GAP;
          cnt_d       = GAP_CNT;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      OUT_GAP: begin
        if (cnt_q == 8'd1) out_state_d = OUT_IDLE;
        else               cnt_d = cnt_q - 8'd1;
      end
      OUT_IDLE: ;
      default: out_state_d = OUT_IDLE;
    endcase
    if (send && can_accept) begin
      out_state_d = OUT_HOLD;
      cnt_d       = HOLD_CNT;
      dout_d      = out_b_q;
    end

    ovr_d = ovr_q;
    if (clr)                 ovr_d = 1'b0;
    if (send && !can_accept) ovr_d = 1'b1;

    out_b_d = out_b_q;
    if (io.we && (io.addr >= 4'h5) && (io.addr <= 4'h8))
      out_b_d[shadow_sel[1:0]] = io.wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_state_q  <= IN_IDLE;
      in_word_q   <= '0;
      out_state_q <= OUT_IDLE;
      dout_q      <= '0;
      out_b_q     <= '0;
      cnt_q       <= '0;
      ovr_q       <= 1'b0;
    end else begin
      in_state_q  <= in_state_d;
      in_word_q   <= in_word_d;
      out_state_q <= out_state_d;
      dout_q      <= dout_d;
      out_b_q     <= out_b_d;
      cnt_q       <= cnt_d;
      ovr_q       <= ovr_d;
    end
  end

  always_comb begin
    io.rdata = '0;
    case (io.addr)
      4'h0: io.rdata = {4'b0000, ovr_q, (out_state_q != OUT_IDLE),
                        (in_state_q == IN_FULL), (in_state_q == IN_WAIT)};
      4'h1: io.rdata = in_word_q[7:0];
      4'h2: io.rdata = in_word_q[15:8];
      4'h3: io.rdata = in_word_q[23:16];
      4'h4: io.rdata = in_word_q[31:24];
      4'h5: io.rdata = out_b_q[0];
      4'h6: io.rdata = out_b_q[1];
      4'h7: io.rdata = out_b_q[2];
      4'h8: io.rdata = out_b_q[3];
      default: io.rdata = '0;
    endcase
  end

  assign io.din_req  = (in_state_q == IN_WAIT);
  assign io.dout     = dout_q;
  assign io.dout_rdy = (out_state_q == OUT_HOLD);

endmodule

// File: tb/tb_float_io_port.sv
// Self-checking bench for float_io_port; expected words are queued when the
// stimulus is driven and popped when the DUT presents them.
module tb_float_io_port;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  float_io_port_if bus ();

  float_io_port #(.DOUT_HOLD(4), .DOUT_GAP(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus)
  );

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [3:0] a, input logic [7:0] d);
    bus.addr = a; bus.wdata = d; bus.we = 1'b1; bus.re = 1'b0;
    tick();
    bus.we = 1'b0;
  endtask

  task automatic cpu_read(input logic [3:0] a, output logic [7:0] d);
    bus.addr = a; bus.re = 1'b1; bus.we = 1'b0;
    #1;
    d = bus.rdata;
    tick();
    bus.re = 1'b0;
  endtask

  task automatic peek(input logic [3:0] a, output logic [7:0] d);
    bus.addr = a; bus.re = 1'b0; bus.we = 1'b0;
    #1;
    d = bus.rdata;
  endtask

  task automatic read_in_word(output logic [31:0] w);
    logic [7:0] b0, b1, b2, b3;
    peek(4'h1, b0); peek(4'h2, b1); peek(4'h3, b2); peek(4'h4, b3);
    w = {b3, b2, b1, b0};
  endtask

  task automatic test_reset();
    logic [7:0] c;
    rst_n = 1'b0;
    bus.addr = '0; bus.wdata = '0; bus.we = 1'b0; bus.re = 1'b0;
    bus.din = '0; bus.din_rdy = 1'b0;
    repeat (2) tick();
    checks++; if (bus.din_req !== 1'b0) begin errors++; $display("FAIL reset_din_req: got %b want 0", bus.din_req); end
    checks++; if (bus.dout_rdy !== 1'b0) begin errors++; $display("FAIL reset_dout_rdy: got %b want 0", bus.dout_rdy); end
    checks++; if (bus.dout !== 32'h0) begin errors++; $display("FAIL reset_dout: got %h want 00000000", bus.dout); end
    peek(4'h0, c);
    checks++; if (c !== 8'h00) begin errors++; $display("FAIL reset_ctrl: got %h want 00", c); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_input();
    int hl;
    logic [31:0] w, e;
    logic [7:0] c;
    bus.din = 32'h40200000; bus.din_rdy = 1'b0;
    cpu_write(4'h0, 8'h01);
    hl = 0;
    exp_q.push_back(32'h40200000);
    for (int i = 0; i < 10; i++) begin
      if (bus.din_req) hl++;
      if (i == 3) bus.din_rdy = 1'b1;
      if (i == 5) bus.din = 32'hDEADBEEF;
      tick();
    end
    checks++; if (hl !== 4) begin errors++; $display("FAIL din_req_cycles: got %0d want 4", hl); end
    checks++; if (bus.din_req !== 1'b0) begin errors++; $display("FAIL din_req_after_capture: got %b want 0", bus.din_req); end
    read_in_word(w);
    e = exp_q.pop_front();
    checks++; if (w !== e) begin errors++; $display("FAIL capture_word: got %h want %h", w, e); end
    peek(4'h0, c);
    checks++; if (c !== 8'h02) begin errors++; $display("FAIL ctrl_in_full: got %h want 02", c); end
  endtask

  task automatic test_consume();
    logic [7:0] b, c;
    logic [31:0] w, e;
    cpu_read(4'h4, b);
    checks++; if (b !== 8'h40) begin errors++; $display("FAIL in_b3_first: got %h want 40", b); end
    peek(4'h0, c);
    checks++; if (c !== 8'h00) begin errors++; $display("FAIL ctrl_consumed: got %h want 00", c); end
    bus.din = 32'hC0490FDB;
    exp_q.push_back(32'hC0490FDB);
    cpu_write(4'h0, 8'h01);
    checks++; if (bus.din_req !== 1'b1) begin errors++; $display("FAIL rereq_din_req: got %b want 1", bus.din_req); end
    tick();
    checks++; if (bus.din_req !== 1'b0) begin errors++; $display("FAIL min_latency_capture: got din_req %b want 0", bus.din_req); end
    read_in_word(w);
    e = exp_q.pop_front();
    checks++; if (w !== e) begin errors++; $display("FAIL recapture_word: got %h want %h", w, e); end
    cpu_read(4'h4, b);
    checks++; if (b !== 8'hC0) begin errors++; $display("FAIL in_b3_second: got %h want c0", b); end
    bus.din_rdy = 1'b0;
  endtask

  task automatic test_output();
    logic [31:0] e;
    logic [7:0] c;
    int hi, lo;
    cpu_write(4'h5, 8'hDB); cpu_write(4'h6, 8'h0F);
    cpu_write(4'h7, 8'h49); cpu_write(4'h8, 8'h40);
    checks++; if (bus.dout !== 32'h0) begin errors++; $display("FAIL shadow_no_direct: got %h want 00000000", bus.dout); end
    exp_q.push_back(32'h40490FDB);
    cpu_write(4'h0, 8'h02);
    e = exp_q.pop_front();
    checks++; if (bus.dout !== e) begin errors++; $display("FAIL dout_first: got %h want %h", bus.dout, e); end
    hi = bus.dout_rdy ? 1 : 0;
    repeat (20) begin tick(); if (bus.dout_rdy) hi++; else break; end
    checks++; if (hi !== 4) begin errors++; $display("FAIL hold_first: got %0d want 4", hi); end
    lo = 1;
    cpu_write(4'h5, 8'h11);
    if (!bus.dout_rdy) lo++;
    peek(4'h0, c);
    checks++; if (c[2] !== 1'b1) begin errors++; $display("FAIL busy_in_gap: got %b want 1", c[2]); end
    exp_q.push_back(32'h40490F11);
    cpu_write(4'h0, 8'h02);
    checks++; if (bus.dout_rdy !== 1'b1 || lo !== 2) begin errors++; $display("FAIL second_pulse_start: got rdy %b gap %0d want 1 and 2", bus.dout_rdy, lo); end
    e = exp_q.pop_front();
    checks++; if (bus.dout !== e) begin errors++; $display("FAIL dout_second: got %h want %h", bus.dout, e); end
    hi = bus.dout_rdy ? 1 : 0;
    repeat (20) begin tick(); if (bus.dout_rdy) hi++; else break; end
    checks++; if (hi !== 4) begin errors++; $display("FAIL hold_second: got %0d want 4", hi); end
    tick(); tick();
    peek(4'h0, c);
    checks++; if (c !== 8'h00) begin errors++; $display("FAIL out_idle_after_gap: got %h want 00", c); end
  endtask

  task automatic test_overrun();
    logic [31:0] e;
    logic [7:0] c;
    int hi;
    exp_q.push_back(32'h40490F11);
    cpu_write(4'h0, 8'h02);
    e = exp_q.pop_front();
    checks++; if (bus.dout !== e) begin errors++; $display("FAIL dout_ovr_base: got %h want %h", bus.dout, e); end
    hi = bus.dout_rdy ? 1 : 0;
    cpu_write(4'h8, 8'h7F); if (bus.dout_rdy) hi++;
    cpu_write(4'h0, 8'h02); if (bus.dout_rdy) hi++;
    peek(4'h0, c);
    checks++; if (c[3] !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b want 1", c[3]); end
    checks++; if (bus.dout !== e) begin errors++; $display("FAIL dout_kept_on_ovr: got %h want %h", bus.dout, e); end
    repeat (20) begin tick(); if (bus.dout_rdy) hi++; else break; end
    checks++; if (hi !== 4) begin errors++; $display("FAIL hold_on_ovr: got %0d want 4", hi); end
    cpu_write(4'h0, 8'h80);
    peek(4'h0, c);
    checks++; if (c[3] !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %b want 0", c[3]); end
    tick();
    exp_q.push_back(32'h7F490F11);
    cpu_write(4'h0, 8'h02);
    e = exp_q.pop_front();
    checks++; if (bus.dout !== e) begin errors++; $display("FAIL dout_third: got %h want %h", bus.dout, e); end
    cpu_write(4'h0, 8'h82);
    peek(4'h0, c);
    checks++; if (c[3] !== 1'b1) begin errors++; $display("FAIL send_clr_together: got %b want 1", c[3]); end
    cpu_write(4'h0, 8'h80);
    repeat (8) tick();
    peek(4'h0, c);
    checks++; if (c !== 8'h00) begin errors++; $display("FAIL idle_after_ovr: got %h want 00", c); end
  endtask

  task automatic test_simul();
    logic [31:0] w, e;
    logic [7:0] c;
    bus.din = 32'h3F800000; bus.din_rdy = 1'b0;
    cpu_write(4'h0, 8'h01);
    exp_q.push_back(32'h3F800000);
    bus.din_rdy = 1'b1;
    tick();
    bus.din_rdy = 1'b0;
    read_in_word(w);
    e = exp_q.pop_front();
    checks++; if (w !== e) begin errors++; $display("FAIL capture_third: got %h want %h", w, e); end
    bus.addr = 4'h0; bus.wdata = 8'h01; bus.we = 1'b1; bus.re = 1'b1;
    tick();
    bus.we = 1'b0; bus.re = 1'b0;
    checks++; if (bus.din_req !== 1'b1) begin errors++; $display("FAIL req_beats_read: got %b want 1", bus.din_req); end
    peek(4'h0, c);
    checks++; if (c !== 8'h01) begin errors++; $display("FAIL ctrl_wait_after_req: got %h want 01", c); end
    bus.din_rdy = 1'b1;
    tick();
    bus.din_rdy = 1'b0;
    checks++; if (bus.din_req !== 1'b0 || bus.dout_rdy !== 1'b0) begin errors++; $display("FAIL pre_combo: got req %b rdy %b want 0 0", bus.din_req, bus.dout_rdy); end
    exp_q.push_back(32'h7F490F11);
    cpu_write(4'h0, 8'h03);
    checks++; if (bus.din_req !== 1'b1 || bus.dout_rdy !== 1'b1) begin errors++; $display("FAIL req_send_combo: got req %b rdy %b want 1 1", bus.din_req, bus.dout_rdy); end
    e = exp_q.pop_front();
    checks++; if (bus.dout !== e) begin errors++; $display("FAIL dout_combo: got %h want %h", bus.dout, e); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] c;
    tick();
    rst_n = 1'b0;
    #1;
    checks++; if (bus.dout_rdy !== 1'b0) begin errors++; $display("FAIL async_rst_dout_rdy: got %b want 0", bus.dout_rdy); end
    checks++; if (bus.din_req !== 1'b0) begin errors++; $display("FAIL async_rst_din_req: got %b want 0", bus.din_req); end
    checks++; if (bus.dout !== 32'h0) begin errors++; $display("FAIL async_rst_dout: got %h want 00000000", bus.dout); end
    peek(4'h0, c);
    checks++; if (c !== 8'h00) begin errors++; $display("FAIL async_rst_ctrl: got %h want 00", c); end
    rst_n = 1'b1;
    tick();
    peek(4'h0, c);
    checks++; if (c !== 8'h00) begin errors++; $display("FAIL post_rst_ctrl: got %h want 00", c); end
  endtask

  initial begin
    test_reset();
    test_input();
    test_consume();
    test_output();
    test_overrun();
    test_simul();
    test_reset_mid();
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL scoreboard_drained: got %0d left want 0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
